// File: rtl/address_bus_arbiter.sv
// address_bus_arbiter: registered request/grant owner of the CPU address bus.
// Fixed-priority or round-robin winner per cycle, with LOCK and hold limit.
module address_bus_arbiter #(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 4,
  parameter int ROUND_ROBIN = 1,
  parameter int MAX_HOLD    = 0,
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [CHANNELS-1:0]       REQ,
  input  logic [CHANNELS-1:0]       LOCK,
  input  logic [CHANNELS*WIDTH-1:0] ADDR_IN,
  output logic [WIDTH-1:0]          ADDRESS_BUS,
  output logic                      BUS_VALID,
  output logic [CHANNELS-1:0]       GRANT,
  output logic [IW-1:0]             GRANT_ID,
  output logic                      TIMEOUT
);

  localparam int HW =
    (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HSAT =
    (MAX_HOLD > 0) ? HW'(MAX_HOLD) : {HW{1'b1}};
  localparam logic [CHANNELS-1:0] ONE =
    {{(CHANNELS-1){1'b0}}, 1'b1};

  logic [HW-1:0]       hold_cnt;
  logic [IW-1:0]       rr_ptr;
  logic [WIDTH-1:0]    addr_a [CHANNELS];
  logic [CHANNELS-1:0] elig;
  logic                owned;
  logic                expired;
  logic                others;
  logic                forced;
  logic                cont;
  logic                found;
  logic [IW-1:0]       win;
  logic [IW-1:0]       rr_nxt;

  // Unflatten the per-channel address bus.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      addr_a[i] = ADDR_IN[i*WIDTH +: WIDTH];
    end
  end

  // Decide whether the current owner keeps the bus or is forced out.
  always_comb begin
    owned   = BUS_VALID && REQ[GRANT_ID]
              && LOCK[GRANT_ID];
    expired = (MAX_HOLD != 0) && (hold_cnt >= HSAT);
    others  = |(REQ & ~GRANT);
    forced  = owned && expired && others;
    cont    = owned && !forced;
    elig    = forced ? (REQ & ~GRANT) : REQ;
  end

  // Winner search starting at rr_ptr (or at 0 for fixed priority).
  always_comb begin
    int t;
    logic [IW-1:0] ti;
    t     = 0;
    ti    = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      t = k;
      if (ROUND_ROBIN != 0) t = t + int'(rr_ptr);
      if (t >= CHANNELS) t = t - CHANNELS;
      ti = IW'(t);
      if (!found && elig[ti]) begin
        found = 1'b1;
        win   = ti;
      end
    end
    rr_nxt = (int'(win) == CHANNELS - 1)
             ? '0 : win + 1'b1;
  end

  // Registered ownership, address, hold counter and pointer.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ADDRESS_BUS <= '0;
      BUS_VALID   <= 1'b0;
      GRANT       <= '0;
      GRANT_ID    <= '0;
      TIMEOUT     <= 1'b0;
      hold_cnt    <= '0;
      rr_ptr      <= '0;
    end else if (cont) begin
      ADDRESS_BUS <= addr_a[GRANT_ID];
      TIMEOUT     <= 1'b0;
      if (hold_cnt != HSAT) hold_cnt <= hold_cnt + 1'b1;
    end else if (found) begin
      ADDRESS_BUS <= addr_a[win];
      BUS_VALID   <= 1'b1;
      GRANT       <= ONE << win;
      GRANT_ID    <= win;
      TIMEOUT     <= forced;
      hold_cnt    <= HW'(1);
      if (ROUND_ROBIN != 0) rr_ptr <= rr_nxt;
    end else begin
      ADDRESS_BUS <= '0;
      BUS_VALID   <= 1'b0;
      GRANT       <= '0;
      GRANT_ID    <= '0;
      TIMEOUT     <= 1'b0;
      hold_cnt    <= '0;
    end
  end

endmodule

// File: tb/tb_address_bus_arbiter.sv
// tb_address_bus_arbiter: directed checks of three arbiter configurations
// (round-robin, fixed priority, round-robin with MAX_HOLD=3) on shared inputs.
module tb_address_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [63:0] addr_in;

  logic [15:0] rr_addr, fp_addr, mh_addr;
  logic        rr_vld, fp_vld, mh_vld;
  logic [3:0]  rr_gnt, fp_gnt, mh_gnt;
  logic [1:0]  rr_id, fp_id, mh_id;
  logic        rr_to, fp_to, mh_to;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  address_bus_arbiter #(.WIDTH(16), .CHANNELS(4),
    .ROUND_ROBIN(1), .MAX_HOLD(0)) u_rr (
    .CLK(clk), .RESET_N(rst_n), .REQ(req), .LOCK(lock),
    .ADDR_IN(addr_in), .ADDRESS_BUS(rr_addr),
    .BUS_VALID(rr_vld), .GRANT(rr_gnt),
    .GRANT_ID(rr_id), .TIMEOUT(rr_to));

  address_bus_arbiter #(.WIDTH(16), .CHANNELS(4),
    .ROUND_ROBIN(0), .MAX_HOLD(0)) u_fp (
    .CLK(clk), .RESET_N(rst_n), .REQ(req), .LOCK(lock),
    .ADDR_IN(addr_in), .ADDRESS_BUS(fp_addr),
    .BUS_VALID(fp_vld), .GRANT(fp_gnt),
    .GRANT_ID(fp_id), .TIMEOUT(fp_to));

  address_bus_arbiter #(.WIDTH(16), .CHANNELS(4),
    .ROUND_ROBIN(1), .MAX_HOLD(3)) u_mh (
    .CLK(clk), .RESET_N(rst_n), .REQ(req), .LOCK(lock),
    .ADDR_IN(addr_in), .ADDRESS_BUS(mh_addr),
    .BUS_VALID(mh_vld), .GRANT(mh_gnt),
    .GRANT_ID(mh_id), .TIMEOUT(mh_to));

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int ch,
                          input logic [15:0] a);
    addr_in[ch*16 +: 16] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    lock  = 4'b0000;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] a;
    rst_n   = 1'b1;
    req     = 4'b0000;
    lock    = 4'b0000;
    addr_in = '0;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_vld", rr_vld, 0);
    chk("rst_gnt", rr_gnt, 0);
    chk("rst_id", rr_id, 0);
    chk("rst_addr", rr_addr, 0);
    chk("rst_to", rr_to, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_vld", rr_vld, 0);
      chk("idle_gnt", rr_gnt, 0);
      chk("idle_fp_vld", fp_vld, 0);
    end

    set_addr(1, 16'h1234);
    set_addr(3, 16'h3333);
    req = 4'b1010;
    step();
    chk("fp_gnt", fp_gnt, 4'b0010);
    chk("fp_id", fp_id, 1);
    chk("fp_addr", fp_addr, 16'h1234);
    chk("fp_vld", fp_vld, 1);

    rst_n = 1'b0;
    #1;
    chk("async_vld", fp_vld, 0);
    chk("async_gnt", fp_gnt, 0);
    chk("async_id", fp_id, 0);
    chk("async_addr", fp_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0000;

    set_addr(0, 16'hA000);
    set_addr(1, 16'hA001);
    set_addr(2, 16'hA002);
    set_addr(3, 16'hA003);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_id", rr_id, i % 4);
      chk("rr_addr", rr_addr, 16'hA000 + i % 4);
      chk("fp_prio_id", fp_id, 0);
    end

    do_reset();
    req  = 4'b0100;
    lock = 4'b0100;
    step();
    chk("lk1_rr", rr_id, 2);
    chk("lk1_fp", fp_id, 2);
    chk("lk1_mh", mh_id, 2);
    req = 4'b0101;
    step();
    chk("lk2_rr", rr_id, 2);
    chk("lk2_mh", mh_id, 2);
    step();
    chk("lk3_rr", rr_id, 2);
    chk("lk3_fp", fp_id, 2);
    chk("lk3_mh", mh_id, 2);
    step();
    chk("lk4_rr", rr_id, 2);
    chk("lk4_fp", fp_id, 2);
    chk("lk4_mh_id", mh_id, 0);
    chk("lk4_mh_to", mh_to, 1);
    lock = 4'b0000;
    step();
    chk("ho_rr_id", rr_id, 0);
    chk("ho_rr_vld", rr_vld, 1);
    chk("ho_rr_addr", rr_addr, 16'hA000);
    chk("ho_fp_id", fp_id, 0);
    chk("ho_mh_id", mh_id, 2);
    chk("ho_mh_to", mh_to, 0);

    do_reset();
    req  = 4'b1010;
    lock = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_hold_id", mh_id, 1);
      chk("to_hold_to", mh_to, 0);
    end
    step();
    chk("to_id", mh_id, 3);
    chk("to_gnt", mh_gnt, 4'b1000);
    chk("to_pulse", mh_to, 1);
    chk("to_addr", mh_addr, 16'hA003);
    step();
    chk("to_after", mh_to, 0);
    chk("to_after_id", mh_id, 1);

    do_reset();
    req  = 4'b0010;
    lock = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("solo_id", mh_id, 1);
      chk("solo_to", mh_to, 0);
      chk("solo_vld", mh_vld, 1);
    end

    do_reset();
    req  = 4'b0001;
    lock = 4'b0001;
    a = 16'hFFFD;
    for (int i = 0; i < 9; i++) begin
      set_addr(0, a);
      step();
      chk("trk_addr", rr_addr, a);
      a = a + 16'd1;
    end
    req  = 4'b0000;
    lock = 4'b0000;
    step();
    chk("end_vld", rr_vld, 0);
    chk("end_addr", rr_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
